// File: rtl/ltc2656_pkg.sv
// Shared constants and frame layout for the LTC-2656 serial responder.
// Commands, broadcast address and the 24-bit command/address/data word.
package ltc2656_pkg;

    localparam logic [3:0] CMD_WR_IN      = 4'd0;
    localparam logic [3:0] CMD_UPD        = 4'd1;
    localparam logic [3:0] CMD_WR_UPD_ALL = 4'd2;
    localparam logic [3:0] CMD_WR_UPD     = 4'd3;
    localparam logic [3:0] CMD_PD         = 4'd4;
    localparam logic [3:0] CMD_PD_CHIP    = 4'd5;
    localparam logic [3:0] CMD_INT_REF    = 4'd6;
    localparam logic [3:0] CMD_EXT_REF    = 4'd7;

    localparam logic [3:0] ADDR_ALL    = 4'hF;
    localparam int         FRAME_BITS  = 24;
    localparam logic [4:0] BIT_CNT_MAX = 5'd31;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [3:0]  addr;
        logic [15:0] data;
    } frame_t;

    // Addresses 8-14 are unassigned on the part and select no channel.
    function automatic logic [7:0] addr_to_sel(input logic [3:0] addr);
        logic [7:0] sel;
        if (addr[3] == 1'b0) begin
            sel = 8'h01 << addr[2:0];
        end else if (addr == ADDR_ALL) begin
            sel = 8'hFF;
        end else begin
            sel = 8'h00;
        end
        return sel;
    endfunction

endpackage

// File: rtl/ltc_2656_responder_spi_frame_rx.sv
// Pin synchroniser stage, edge detection and 24-bit frame capture.
// Emits one-cycle frame_valid/frame_short pulses when csld rises.
module spi_frame_rx
    import ltc2656_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        sck_i,
    input  logic        sdi_i,
    input  logic        csld_i,
    input  logic        ldac_n_i,
    input  logic        clr_n_i,
    output logic        ldac_n_q_o,
    output logic        clr_n_q_o,
    output logic        frame_valid_o,
    output logic        frame_short_o,
    output logic [23:0] word_o
);

    localparam logic [4:0] FRAME_BITS_C = 5'(FRAME_BITS);

    logic        sck_q, sck_qq, sdi_q, csld_q, csld_qq, ldac_n_q, clr_n_q;
    logic        in_frame_q, in_frame_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [23:0] sr_q, sr_d;
    logic        sck_rise_s, csld_fall_s, csld_rise_s;

    assign sck_rise_s  = sck_q & ~sck_qq;
    assign csld_fall_s = ~csld_q & csld_qq;
    assign csld_rise_s = csld_q & ~csld_qq;

    // Shift happens before the end-of-frame length test in the same cycle.
    always_comb begin
        in_frame_d    = in_frame_q;
        frame_valid_o = 1'b0;
        frame_short_o = 1'b0;
        if (in_frame_q && sck_rise_s) begin
            sr_d      = {sr_q[22:0], sdi_q};
            bit_cnt_d = (bit_cnt_q == BIT_CNT_MAX) ? bit_cnt_q : bit_cnt_q + 5'd1;
        end else begin
            sr_d      = sr_q;
            bit_cnt_d = bit_cnt_q;
        end
        if (csld_fall_s) begin
            in_frame_d = 1'b1;
            bit_cnt_d  = 5'd0;
        end else if (csld_rise_s && in_frame_q) begin
            in_frame_d    = 1'b0;
            frame_valid_o = (bit_cnt_d >= FRAME_BITS_C);
            frame_short_o = (bit_cnt_d <  FRAME_BITS_C);
        end else begin
            in_frame_d = in_frame_q;
        end
    end

    // csld/sck history resets low so a csld held low through reset needs a fresh fall.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            sck_q      <= 1'b0;
            sck_qq     <= 1'b0;
            sdi_q      <= 1'b0;
            csld_q     <= 1'b0;
            csld_qq    <= 1'b0;
            ldac_n_q   <= 1'b1;
            clr_n_q    <= 1'b1;
            in_frame_q <= 1'b0;
            bit_cnt_q  <= 5'd0;
            sr_q       <= 24'h000000;
        end else begin
            sck_q      <= sck_i;
            sck_qq     <= sck_q;
            sdi_q      <= sdi_i;
            csld_q     <= csld_i;
            csld_qq    <= csld_q;
            ldac_n_q   <= ldac_n_i;
            clr_n_q    <= clr_n_i;
            in_frame_q <= in_frame_d;
            bit_cnt_q  <= bit_cnt_d;
            sr_q       <= sr_d;
        end
    end

    assign ldac_n_q_o = ldac_n_q;
    assign clr_n_q_o  = clr_n_q;
    assign word_o     = sr_d;

endmodule

// File: rtl/ltc_2656_responder.sv
// LTC-2656 octal DAC stand-in: register file, command decode, LDAC/CLR and readback.
// Event priority per cycle: CLR over LDAC over frame execute.
module ltc_2656_responder
    import ltc2656_pkg::*;
#(
    parameter int          NUM_CH     = 8,
    parameter logic [15:0] RESET_CODE = 16'h0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        sck,
    input  logic        sdi,
    input  logic        csld,
    input  logic        ldac_n,
    input  logic        clr_n,
    input  logic [2:0]  rd_channel,
    output logic [15:0] rd_value,
    output logic [7:0]  pd_mask,
    output logic        ext_ref,
    output logic [7:0]  upd_pulse,
    output logic [15:0] frame_cnt,
    output logic        frame_err
);

    logic        ldac_n_q_s, clr_n_q_s, frame_valid_s, frame_short_s;
    logic [23:0] word_s;
    frame_t      frm_s;
    logic [7:0]  sel_s, wr_mask_s, upd_mask_s, pd_cmd_s;
    logic        ref_cmd_s;

    logic [15:0] inp_q [NUM_CH];
    logic [15:0] inp_d [NUM_CH];
    logic [15:0] dac_q [NUM_CH];
    logic [15:0] dac_d [NUM_CH];
    logic [15:0] inp_c_s [NUM_CH];
    logic [15:0] dac_c_s [NUM_CH];
    logic [7:0]  pd_q, pd_d, upd_q, upd_d;
    logic        ext_ref_q, ext_ref_d, frame_err_q;
    logic [15:0] frame_cnt_q, frame_cnt_d, rd_value_q;

    spi_frame_rx u_rx (
        .clk           (clk),
        .resetn        (resetn),
        .sck_i         (sck),
        .sdi_i         (sdi),
        .csld_i        (csld),
        .ldac_n_i      (ldac_n),
        .clr_n_i       (clr_n),
        .ldac_n_q_o    (ldac_n_q_s),
        .clr_n_q_o     (clr_n_q_s),
        .frame_valid_o (frame_valid_s),
        .frame_short_o (frame_short_s),
        .word_o        (word_s)
    );

    // Command decode into write/update masks and pd/ref next values.
    always_comb begin
        frm_s      = frame_t'(word_s);
        sel_s      = addr_to_sel(frm_s.addr);
        upd_mask_s = 8'h00;
        pd_cmd_s   = pd_q;
        ref_cmd_s  = ext_ref_q;
        case (frm_s.cmd)
            CMD_UPD, CMD_WR_UPD: begin
                upd_mask_s = sel_s;
                pd_cmd_s   = pd_q & ~sel_s;
            end
            CMD_WR_UPD_ALL: begin
                upd_mask_s = 8'hFF;
                pd_cmd_s   = 8'h00;
            end
            CMD_PD:      pd_cmd_s  = pd_q | sel_s;
            CMD_PD_CHIP: pd_cmd_s  = 8'hFF;
            CMD_INT_REF: ref_cmd_s = 1'b0;
            CMD_EXT_REF: ref_cmd_s = 1'b1;
            default:     pd_cmd_s  = pd_q;
        endcase
        if (frm_s.cmd == CMD_WR_IN || frm_s.cmd == CMD_WR_UPD_ALL || frm_s.cmd == CMD_WR_UPD) begin
            wr_mask_s = sel_s;
        end else begin
            wr_mask_s = 8'h00;
        end
        if (!frame_valid_s) begin
            wr_mask_s  = 8'h00;
            upd_mask_s = 8'h00;
        end else begin
            wr_mask_s  = wr_mask_s;
            upd_mask_s = upd_mask_s;
        end
    end

    // Layered next state: frame write, then LDAC copy of post-write inputs, then CLR.
    always_comb begin
        for (int n = 0; n < NUM_CH; n++) begin
            inp_c_s[n] = wr_mask_s[n]  ? frm_s.data : inp_q[n];
            dac_c_s[n] = upd_mask_s[n] ? inp_c_s[n] : dac_q[n];
            inp_d[n]   = !clr_n_q_s ? RESET_CODE : inp_c_s[n];
            dac_d[n]   = !clr_n_q_s ? RESET_CODE : (!ldac_n_q_s ? inp_c_s[n] : dac_c_s[n]);
        end
        upd_d       = !clr_n_q_s ? 8'h00 : (!ldac_n_q_s ? 8'hFF : upd_mask_s);
        pd_d        = frame_valid_s ? pd_cmd_s : pd_q;
        ext_ref_d   = frame_valid_s ? ref_cmd_s : ext_ref_q;
        frame_cnt_d = frame_valid_s ? frame_cnt_q + 16'd1 : frame_cnt_q;
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int n = 0; n < NUM_CH; n++) begin
                inp_q[n] <= RESET_CODE;
                dac_q[n] <= RESET_CODE;
            end
            pd_q        <= 8'h00;
            upd_q       <= 8'h00;
            ext_ref_q   <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= 16'd0;
            rd_value_q  <= RESET_CODE;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                inp_q[n] <= inp_d[n];
                dac_q[n] <= dac_d[n];
            end
            pd_q        <= pd_d;
            upd_q       <= upd_d;
            ext_ref_q   <= ext_ref_d;
            frame_err_q <= frame_short_s;
            frame_cnt_q <= frame_cnt_d;
            rd_value_q  <= dac_q[rd_channel];
        end
    end

    assign rd_value  = rd_value_q;
    assign pd_mask   = pd_q;
    assign ext_ref   = ext_ref_q;
    assign upd_pulse = upd_q;
    assign frame_cnt = frame_cnt_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ltc_2656_responder.sv
// Directed bench for ltc_2656_responder: a table of frames with hand-computed
// expected state, plus sequences for LDAC, CLR and reset in mid-frame.
module tb_ltc_2656_responder;

    logic        clk = 1'b0;
    logic        resetn, sck, sdi, csld, ldac_n, clr_n;
    logic [2:0]  rd_channel;
    logic [15:0] rd_value, frame_cnt;
    logic [7:0]  pd_mask, upd_pulse;
    logic        ext_ref, frame_err;

    int          n_pass = 0;
    int          n_total = 0;
    int          upd_cycles, err_cycles;
    logic [7:0]  upd_seen;

    typedef struct {
        logic [31:0] word;
        int          nbits;
        logic [2:0]  ch;
        logic [15:0] exp_rd;
        logic [7:0]  exp_pd;
        logic        exp_ref;
        logic [15:0] exp_cnt;
        logic [7:0]  exp_upd;
        int          exp_err;
    } vec_t;

    vec_t vecs [14];

    always #5 clk = ~clk;

    ltc_2656_responder #(.NUM_CH(8), .RESET_CODE(16'h0000)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .sck        (sck),
        .sdi        (sdi),
        .csld       (csld),
        .ldac_n     (ldac_n),
        .clr_n      (clr_n),
        .rd_channel (rd_channel),
        .rd_value   (rd_value),
        .pd_mask    (pd_mask),
        .ext_ref    (ext_ref),
        .upd_pulse  (upd_pulse),
        .frame_cnt  (frame_cnt),
        .frame_err  (frame_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Advance n clocks; outputs are observed on the falling edge, inputs change 1ns after the rising edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (upd_pulse != 8'h00) begin
                upd_cycles++;
                upd_seen |= upd_pulse;
            end
            if (frame_err) err_cycles++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        upd_cycles = 0;
        err_cycles = 0;
        upd_seen   = 8'h00;
    endtask

    task automatic shift_bits(input logic [31:0] word, input int nbits);
        csld = 1'b0;
        cyc(2);
        for (int i = nbits - 1; i >= 0; i--) begin
            sdi = word[i];
            cyc(2);
            sck = 1'b1;
            cyc(2);
            sck = 1'b0;
        end
    endtask

    task automatic end_frame();
        cyc(2);
        csld = 1'b1;
    endtask

    task automatic send_frame(input logic [31:0] word, input int nbits);
        shift_bits(word, nbits);
        end_frame();
        cyc(8);
    endtask

    task automatic rd_chk(input string name, input logic [2:0] ch, input logic [15:0] exp);
        rd_channel = ch;
        cyc(3);
        chk(name, {16'h0000, rd_value}, {16'h0000, exp});
    endtask

    initial begin
        resetn = 1'b0; sck = 1'b0; sdi = 1'b0; csld = 1'b1;
        ldac_n = 1'b1; clr_n = 1'b1; rd_channel = 3'd0;
        clear_mon();

        //           word           bits ch    rd        pd     ref   cnt     upd    err
        vecs[0]  = '{32'h0032ABCD, 24, 3'd2, 16'hABCD, 8'h00, 1'b0, 16'd1,  8'h04, 0};
        vecs[1]  = '{32'h000F1234, 24, 3'd2, 16'hABCD, 8'h00, 1'b0, 16'd2,  8'h00, 0};
        vecs[2]  = '{32'h00450000, 24, 3'd0, 16'h0000, 8'h20, 1'b0, 16'd3,  8'h00, 0};
        vecs[3]  = '{32'h00150000, 24, 3'd5, 16'h1234, 8'h00, 1'b0, 16'd4,  8'h20, 0};
        vecs[4]  = '{32'h007F0000, 24, 3'd2, 16'hABCD, 8'h00, 1'b1, 16'd5,  8'h00, 0};
        vecs[5]  = '{32'h00037FFF, 20, 3'd7, 16'h0000, 8'h00, 1'b1, 16'd5,  8'h00, 1};
        vecs[6]  = '{32'h03310055, 26, 3'd1, 16'h0055, 8'h00, 1'b1, 16'd6,  8'h02, 0};
        vecs[7]  = '{32'h005F0000, 24, 3'd1, 16'h0055, 8'hFF, 1'b1, 16'd7,  8'h00, 0};
        vecs[8]  = '{32'h0023BEEF, 24, 3'd3, 16'hBEEF, 8'h00, 1'b1, 16'd8,  8'hFF, 0};
        vecs[9]  = '{32'h006F0000, 24, 3'd2, 16'h1234, 8'h00, 1'b0, 16'd9,  8'h00, 0};
        vecs[10] = '{32'h00925555, 24, 3'd2, 16'h1234, 8'h00, 1'b0, 16'd10, 8'h00, 0};
        vecs[11] = '{32'h00397777, 24, 3'd7, 16'h1234, 8'h00, 1'b0, 16'd11, 8'h00, 0};
        vecs[12] = '{32'h004F0000, 24, 3'd1, 16'h0055, 8'hFF, 1'b0, 16'd12, 8'h00, 0};
        vecs[13] = '{32'h00100000, 24, 3'd0, 16'h1234, 8'hFE, 1'b0, 16'd13, 8'h01, 0};

        cyc(3);
        resetn = 1'b1;
        cyc(3);
        chk("reset_rd_value",  {16'h0000, rd_value},  32'h0);
        chk("reset_pd_mask",   {24'h0, pd_mask},      32'h0);
        chk("reset_ext_ref",   {31'h0, ext_ref},      32'h0);
        chk("reset_upd_pulse", {24'h0, upd_pulse},    32'h0);
        chk("reset_frame_cnt", {16'h0000, frame_cnt}, 32'h0);
        chk("reset_frame_err", {31'h0, frame_err},    32'h0);

        for (int v = 0; v < 14; v++) begin
            clear_mon();
            send_frame(vecs[v].word, vecs[v].nbits);
            rd_chk($sformatf("vec%0d_rd_value", v), vecs[v].ch, vecs[v].exp_rd);
            chk($sformatf("vec%0d_pd_mask", v),   {24'h0, pd_mask},      {24'h0, vecs[v].exp_pd});
            chk($sformatf("vec%0d_ext_ref", v),   {31'h0, ext_ref},      {31'h0, vecs[v].exp_ref});
            chk($sformatf("vec%0d_frame_cnt", v), {16'h0000, frame_cnt}, {16'h0000, vecs[v].exp_cnt});
            chk($sformatf("vec%0d_upd_seen", v),  {24'h0, upd_seen},     {24'h0, vecs[v].exp_upd});
            chk($sformatf("vec%0d_upd_cycles", v), upd_cycles, (vecs[v].exp_upd != 8'h00) ? 1 : 0);
            chk($sformatf("vec%0d_frame_err", v), err_cycles, vecs[v].exp_err);
        end

        // LDAC: inputs written to 0x4321, DACs follow only once ldac_n is low.
        clear_mon();
        send_frame(32'h000F4321, 24);
        rd_chk("ldac_before", 3'd2, 16'h1234);
        chk("ldac_before_upd", upd_cycles, 0);
        ldac_n = 1'b0;
        cyc(2);
        ldac_n = 1'b1;
        cyc(5);
        chk("ldac_upd_cycles", upd_cycles, 2);
        chk("ldac_upd_seen", {24'h0, upd_seen}, 32'h000000FF);
        for (int c = 0; c < 8; c++) begin
            rd_chk($sformatf("ldac_dac%0d", c), 3'(c), 16'h4321);
        end
        chk("ldac_frame_cnt", {16'h0000, frame_cnt}, 32'd14);

        // CLR held across execute of 0x3_0_FFFF: writes discarded, frame counted.
        clear_mon();
        shift_bits(32'h0030FFFF, 24);
        clr_n = 1'b0;
        end_frame();
        cyc(6);
        clr_n = 1'b1;
        cyc(4);
        chk("clr_frame_cnt", {16'h0000, frame_cnt}, 32'd15);
        chk("clr_upd_seen", {24'h0, upd_seen}, 32'h0);
        chk("clr_pd_mask", {24'h0, pd_mask}, 32'h000000FE);
        rd_chk("clr_dac0", 3'd0, 16'h0000);
        rd_chk("clr_dac5", 3'd5, 16'h0000);
        clear_mon();
        send_frame(32'h00100000, 24);
        rd_chk("clr_inp0_cleared", 3'd0, 16'h0000);
        chk("clr_upd_after", {24'h0, upd_seen}, 32'h00000001);
        chk("clr_frame_cnt2", {16'h0000, frame_cnt}, 32'd16);

        // Reset at bit 10 of a frame: everything back to reset values, no frame_err.
        send_frame(32'h007F0000, 24);
        chk("pre_reset_ext_ref", {31'h0, ext_ref}, 32'h1);
        clear_mon();
        shift_bits(32'h0035AAAA, 10);
        resetn = 1'b0;
        cyc(2);
        csld = 1'b1;
        sck  = 1'b0;
        cyc(1);
        resetn = 1'b1;
        cyc(6);
        chk("rst_mid_frame_err", err_cycles, 0);
        chk("rst_mid_pd_mask", {24'h0, pd_mask}, 32'h0);
        chk("rst_mid_ext_ref", {31'h0, ext_ref}, 32'h0);
        chk("rst_mid_frame_cnt", {16'h0000, frame_cnt}, 32'h0);
        rd_chk("rst_mid_dac3", 3'd3, 16'h0000);
        clear_mon();
        send_frame(32'h0036CAFE, 24);
        rd_chk("post_rst_dac6", 3'd6, 16'hCAFE);
        chk("post_rst_frame_cnt", {16'h0000, frame_cnt}, 32'd1);
        chk("post_rst_upd_seen", {24'h0, upd_seen}, 32'h00000040);
        chk("post_rst_frame_err", err_cycles, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
